mul_unit_pipe: RTL and testbench

Parametrised, fully pipelined integer multiplier functional unit for the Tomasulo back end. It is the successor of the single-issue multiply unit. It accepts one operation per cycle from the multiply reservation stations and tags every result with its RS label. It supports four multiply modes and holds a finished result under CDB backpressure until the CDB arbiter grants it, with a flush input for squashing in-flight work.

---
 rtl/mul_unit_pipe.sv | 174 +++++++++++++++++
 tb/tb_mul_unit_pipe.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_unit_pipe.sv
// Purpose : fully pipelined integer multiplier (MUL/MULH/MULHU/MULHSU) for the Tomasulo back end, results tagged with RS label.
// Latency : LAT = 1+log2(WIDTH) cycles issue-to-outValid (6 for WIDTH=32), 1 op/cycle, strict issue order.
// Backpr. : whole pipe freezes while a result waits for outAck; inReady = !outValid || outAck.
//
// Ports:
//   clk, nRST               clock (rising edge), asynchronous active-low reset
//   inValid/inReady         issue handshake from the multiply reservation stations
//   op, dataIn1, dataIn2    mode (00 MUL, 01 MULH, 10 MULHU, 11 MULHSU) and operands
//   labelIn / labelOut      RS tag travelling alongside the operation
//   flush                   synchronous squash of everything in flight
//   outValid/outAck/result  CDB handshake and selected product half
//   inFlight                valid ops in the pipe including the output stage
module mul_unit_pipe #(
    parameter  int WIDTH   = 32,
    parameter  int LABEL_W = 4,
    localparam int LAT     = 1 + $clog2(WIDTH),
    localparam int CNT_W   = $clog2(LAT + 1)
) (
    input  logic               clk,
    input  logic               nRST,
    input  logic               inValid,
    output logic               inReady,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   dataIn1,
    input  logic [WIDTH-1:0]   dataIn2,
    input  logic [LABEL_W-1:0] labelIn,
    input  logic               flush,
    output logic               outValid,
    input  logic               outAck,
    output logic [WIDTH-1:0]   result,
    output logic [LABEL_W-1:0] labelOut,
    output logic [CNT_W-1:0]   inFlight
);

    localparam int LOG2W = LAT - 1;
    localparam int PW    = 2 * WIDTH;
    // All stored adder-tree terms: WIDTH + WIDTH/2 + ... + 2.
    localparam int NTERM = PW - 2;

    if (WIDTH < 8 || WIDTH > 64 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("mul_unit_pipe: WIDTH must be a power of two in 8..64");
    end

    // First index of tree level k inside r_tree (level 0 = partial products).
    function automatic int lvl_base(input int k);
        return PW - 2 * (WIDTH >> k);
    endfunction

    logic                w_adv;
    logic                w_acc;
    logic                w_ret;
    logic                w_a_sgn;
    logic                w_b_sgn;
    logic [PW-1:0]       w_a_ext;
    logic [PW-1:0]       w_pp [WIDTH];
    logic [PW-1:0]       w_sum;
    logic [WIDTH-1:0]    w_sel;

    // r_vld[s] is the valid bit of stage s+1; r_vld[LAT-1] is the output stage.
    logic [LAT-1:0]      r_vld;
    logic [1:0]          r_op  [LAT-1];
    logic [LABEL_W-1:0]  r_lbl [LAT-1];
    logic [PW-1:0]       r_tree [NTERM];
    logic [WIDTH-1:0]    r_result;
    logic [LABEL_W-1:0]  r_label_out;
    logic [CNT_W-1:0]    r_cnt;

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign w_adv   = !r_vld[LAT-1] || outAck;
    assign w_acc   = inValid && w_adv && !flush;
    assign w_ret   = r_vld[LAT-1] && outAck;
    assign inReady = w_adv;

    // ------------------------------------------------------------------
    // Partial products, computed modulo 2^(2*WIDTH).
    // dataIn1 is sign- or zero-extended to full product width, so every
    // row already carries the multiplicand's sign. A signed multiplier has
    // weight -2^(WIDTH-1) on its top bit, so that row is subtracted.
    // ------------------------------------------------------------------
    assign w_a_sgn = (op == 2'b01) || (op == 2'b11);
    assign w_b_sgn = (op == 2'b01);
    assign w_a_ext = w_a_sgn ? {{WIDTH{dataIn1[WIDTH-1]}}, dataIn1}
                             : {{WIDTH{1'b0}}, dataIn1};

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_pp[i] = '0;
            if (dataIn2[i]) begin
                if (i == WIDTH - 1 && w_b_sgn) begin
                    w_pp[i] = '0 - (w_a_ext << i);
                end else begin
                    w_pp[i] = w_a_ext << i;
                end
            end
        end
    end

    // Last tree level is folded into the output stage together with the half select.
    assign w_sum = r_tree[NTERM-2] + r_tree[NTERM-1];
    assign w_sel = (r_op[LAT-2] == 2'b00) ? w_sum[WIDTH-1:0] : w_sum[PW-1:WIDTH];

    // ------------------------------------------------------------------
    // Control: valid chain and occupancy counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_vld <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_vld <= '0;
            r_cnt <= '0;
        end else begin
            if (w_adv) begin
                r_vld <= {r_vld[LAT-2:0], w_acc};
            end
            case ({w_acc, w_ret})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Datapath: partial products, adder tree, tag pipe and output stage.
    // Bubbles shift garbage data alongside a cleared valid bit.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            for (int t = 0; t < NTERM; t++) begin
                r_tree[t] <= '0;
            end
            for (int s = 0; s < LAT - 1; s++) begin
                r_op[s]  <= '0;
                r_lbl[s] <= '0;
            end
            r_result    <= '0;
            r_label_out <= '0;
        end else if (w_adv) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_tree[i] <= w_pp[i];
            end
            for (int k = 1; k < LOG2W; k++) begin
                for (int j = 0; j < (WIDTH >> k); j++) begin
                    r_tree[lvl_base(k) + j] <= r_tree[lvl_base(k-1) + 2*j]
                                             + r_tree[lvl_base(k-1) + 2*j + 1];
                end
            end
            r_op[0]  <= op;
            r_lbl[0] <= labelIn;
            for (int s = 1; s < LAT - 1; s++) begin
                r_op[s]  <= r_op[s-1];
                r_lbl[s] <= r_lbl[s-1];
            end
            r_result    <= w_sel;
            r_label_out <= r_lbl[LAT-2];
        end
    end

    assign outValid = r_vld[LAT-1];
    assign result   = r_result;
    assign labelOut = r_label_out;
    assign inFlight = r_cnt;

    // A stalled result must stay put until the CDB takes it.
    a_hold_stable: assert property (@(posedge clk) disable iff (!nRST)
        (outValid && !outAck && !flush) |=> (outValid && $stable(result) && $stable(labelOut)));

    a_cnt_bound: assert property (@(posedge clk) disable iff (!nRST)
        (int'(inFlight) <= LAT));

endmodule

// File: tb/tb_mul_unit_pipe.sv
module tb_mul_unit_pipe;

    localparam int WIDTH   = 32;
    localparam int LABEL_W = 4;

    logic               clk     = 1'b0;
    logic               nRST    = 1'b1;
    logic               inValid = 1'b0;
    logic [1:0]         op      = 2'b00;
    logic [WIDTH-1:0]   dataIn1 = '0;
    logic [WIDTH-1:0]   dataIn2 = '0;
    logic [LABEL_W-1:0] labelIn = '0;
    logic               flush   = 1'b0;
    logic               outAck  = 1'b0;
    logic               inReady;
    logic               outValid;
    logic [WIDTH-1:0]   result;
    logic [LABEL_W-1:0] labelOut;
    logic [2:0]         inFlight;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mul_unit_pipe #(.WIDTH(WIDTH), .LABEL_W(LABEL_W)) dut (
        .clk      (clk),
        .nRST     (nRST),
        .inValid  (inValid),
        .inReady  (inReady),
        .op       (op),
        .dataIn1  (dataIn1),
        .dataIn2  (dataIn2),
        .labelIn  (labelIn),
        .flush    (flush),
        .outValid (outValid),
        .outAck   (outAck),
        .result   (result),
        .labelOut (labelOut),
        .inFlight (inFlight)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] o, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [LABEL_W-1:0] l);
        inValid = v;
        op      = o;
        dataIn1 = a;
        dataIn2 = b;
        labelIn = l;
    endtask

    task automatic test_reset();
        #1 nRST = 1'b0;
        #10;
        checks++;
        if (outValid !== 1'b0 || inFlight !== 3'd0 || result !== 32'd0 || labelOut !== 4'd0) begin
            errors++;
            $display("FAIL reset_state: got outValid=%0b inFlight=%0d result=%h labelOut=%0d, expected 0 0 0 0",
                     outValid, inFlight, result, labelOut);
        end
        #2 nRST = 1'b1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL reset_inready: got %0b, expected 1", inReady);
        end
        tick();
    endtask

    task automatic test_basic();
        outAck = 1'b1;
        drive(1'b1, 2'b00, 32'd7, 32'd6, 4'd3);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
        checks++;
        if (inFlight !== 3'd1) begin
            errors++;
            $display("FAIL basic_inflight_issue: got %0d, expected 1", inFlight);
        end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++;
            if (outValid !== (k == 5)) begin
                errors++;
                $display("FAIL basic_latency k=%0d: got outValid=%0b, expected %0b", k, outValid, (k == 5));
            end
        end
        checks++;
        if (result !== 32'd42 || labelOut !== 4'd3) begin
            errors++;
            $display("FAIL basic_result: got result=%0d label=%0d, expected 42 3", result, labelOut);
        end
        tick();
        checks++;
        if (outValid !== 1'b0 || inFlight !== 3'd0) begin
            errors++;
            $display("FAIL basic_drain: got outValid=%0b inFlight=%0d, expected 0 0", outValid, inFlight);
        end
    endtask

    task automatic test_modes();
        logic [1:0]       v_op  [8] = '{2'b01, 2'b10, 2'b11, 2'b00, 2'b00, 2'b01, 2'b11, 2'b10};
        logic [WIDTH-1:0] v_a   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000,
                                        32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'hFFFFFFFF};
        logic [WIDTH-1:0] v_b   [8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
                                        32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'd2};
        logic [WIDTH-1:0] v_exp [8] = '{32'h00000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000000,
                                        32'h00000001, 32'h40000000, 32'h80000000, 32'h00000001};
        outAck = 1'b1;
        for (int i = 0; i < 8; i++) begin
            int n;
            n = 0;
            drive(1'b1, v_op[i], v_a[i], v_b[i], 4'(i + 8));
            tick();
            drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
            for (int w = 1; w <= 10; w++) begin
                tick();
                if (outValid === 1'b1) begin
                    n = w;
                    break;
                end
            end
            checks++;
            if (n != 5 || result !== v_exp[i] || labelOut !== 4'(i + 8)) begin
                errors++;
                $display("FAIL mode_%0d op=%0d: got wait=%0d result=%h label=%0d, expected 5 %h %0d",
                         i, v_op[i], n, result, labelOut, v_exp[i], i + 8);
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int n     = 0;
        int peak  = 0;
        outAck = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c < 6) drive(1'b1, 2'b00, 32'(c), 32'(c + 1), 4'(c));
            else       drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
            tick();
            if (int'(inFlight) > peak) peak = int'(inFlight);
            if (outValid === 1'b1) begin
                checks++;
                if (n > 5 || result !== 32'(n * (n + 1)) || labelOut !== 4'(n) || c != 5 + n) begin
                    errors++;
                    $display("FAIL b2b_result_%0d: got result=%0d label=%0d cycle=%0d, expected %0d %0d %0d",
                             n, result, labelOut, c, n * (n + 1), n, 5 + n);
                end
                n++;
            end
        end
        checks++;
        if (n != 6 || peak != 6) begin
            errors++;
            $display("FAIL b2b_count: got results=%0d peak=%0d, expected 6 6", n, peak);
        end
    endtask

    task automatic test_backpressure();
        int n = 0;
        outAck = 1'b0;
        drive(1'b1, 2'b00, 32'd3, 32'd5, 4'd7);
        tick();
        drive(1'b1, 2'b00, 32'd4, 32'd4, 4'd8);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
        for (int w = 1; w <= 10; w++) begin
            if (outValid === 1'b1) break;
            tick();
            n = w;
        end
        checks++;
        if (outValid !== 1'b1 || n != 4 || result !== 32'd15 || labelOut !== 4'd7) begin
            errors++;
            $display("FAIL bp_first: got outValid=%0b wait=%0d result=%0d label=%0d, expected 1 4 15 7",
                     outValid, n, result, labelOut);
        end
        for (int s = 0; s < 4; s++) begin
            drive(1'b1, 2'b00, 32'd9, 32'd9, 4'd9);
            tick();
            checks++;
            if (inReady !== 1'b0 || outValid !== 1'b1 || result !== 32'd15 ||
                labelOut !== 4'd7 || inFlight !== 3'd2) begin
                errors++;
                $display("FAIL bp_stall_%0d: got inReady=%0b outValid=%0b result=%0d label=%0d inFlight=%0d, expected 0 1 15 7 2",
                         s, inReady, outValid, result, labelOut, inFlight);
            end
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
        outAck = 1'b1;
        tick();
        checks++;
        if (outValid !== 1'b1 || result !== 32'd16 || labelOut !== 4'd8 || inFlight !== 3'd1) begin
            errors++;
            $display("FAIL bp_second: got outValid=%0b result=%0d label=%0d inFlight=%0d, expected 1 16 8 1",
                     outValid, result, labelOut, inFlight);
        end
        tick();
        checks++;
        if (outValid !== 1'b0 || inFlight !== 3'd0) begin
            errors++;
            $display("FAIL bp_drain: got outValid=%0b inFlight=%0d, expected 0 0", outValid, inFlight);
        end
    endtask

    task automatic test_flush();
        outAck = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 2'b00, 32'(i), 32'd3, 4'(i));
            tick();
        end
        drive(1'b1, 2'b00, 32'd5, 32'd5, 4'd4);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (outValid !== 1'b0 || inFlight !== 3'd0) begin
            errors++;
            $display("FAIL flush_clear: got outValid=%0b inFlight=%0d, expected 0 0", outValid, inFlight);
        end
        drive(1'b1, 2'b00, 32'd9, 32'd9, 4'd2);
        tick();
        drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            checks++;
            if (outValid !== (k == 5)) begin
                errors++;
                $display("FAIL flush_after k=%0d: got outValid=%0b, expected %0b", k, outValid, (k == 5));
            end
            if (k == 5) begin
                checks++;
                if (result !== 32'd81 || labelOut !== 4'd2) begin
                    errors++;
                    $display("FAIL flush_new_result: got result=%0d label=%0d, expected 81 2", result, labelOut);
                end
            end
        end
        checks++;
        if (inFlight !== 3'd0) begin
            errors++;
            $display("FAIL flush_final_inflight: got %0d, expected 0", inFlight);
        end
    endtask

    task automatic test_reset_mid();
        bit stale = 1'b0;
        outAck = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 2'b01, 32'd11 + 32'(i), 32'hFFFFFFF0, 4'(i + 1));
            tick();
        end
        drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0);
        checks++;
        if (inFlight !== 3'd4) begin
            errors++;
            $display("FAIL rst_pre_inflight: got %0d, expected 4", inFlight);
        end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (outValid !== 1'b0 || inFlight !== 3'd0 || result !== 32'd0 || labelOut !== 4'd0) begin
            errors++;
            $display("FAIL rst_async: got outValid=%0b inFlight=%0d result=%h labelOut=%0d, expected 0 0 0 0",
                     outValid, inFlight, result, labelOut);
        end
        #2 nRST = 1'b1;
        #1;
        checks++;
        if (inReady !== 1'b1) begin
            errors++;
            $display("FAIL rst_inready: got %0b, expected 1", inReady);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            if (outValid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale || inFlight !== 3'd0) begin
            errors++;
            $display("FAIL rst_no_stale: got stale=%0b inFlight=%0d, expected 0 0", stale, inFlight);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
